// File: rtl/fluid_board_soc_memory_tester.sv
// ============================================================================
//  Module   : fluid_board_soc_memory_tester
//  Purpose  : Avalon-MM fill/verify memory tester with pipelined read checking.
//             Define MEMORY_TESTER_ADDR_PATTERN_EN to XOR the word address
//             into the data pattern.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module fluid_board_soc_memory_tester #(
   parameter int ADDR_W       = 15,
   parameter int DATA_W       = 64,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [1:0]            mode,
   input  logic [ADDR_W-1:0]     base_address,
   input  logic [ADDR_W:0]       word_count,
   input  logic [DATA_W-1:0]     pattern,
   output logic                  busy,
   output logic                  done,
   output logic [15:0]           error_count,
   output logic [ADDR_W-1:0]     first_error_address,
   output logic [ADDR_W-1:0]     avm_address,
   output logic [DATA_W/8-1:0]   avm_byteenable,
   output logic                  avm_chipselect,
   output logic                  avm_write,
   output logic                  avm_read,
   output logic [DATA_W-1:0]     avm_writedata,
   output logic                  avm_clken,
   input  logic [DATA_W-1:0]     avm_readdata,
   input  logic                  avm_waitrequest
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WRITE = 3'd1;
   localparam logic [2:0] S_READ  = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]          state_q, state_d;
   logic                verify_q;
   logic [ADDR_W-1:0]   base_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [ADDR_W:0]     count_q;
   logic [ADDR_W:0]     remain_q;
   logic [DATA_W-1:0]   pattern_q;
   logic [15:0]         err_cnt_q;
   logic [ADDR_W-1:0]   first_err_q;
   logic                err_seen_q;
   logic [READ_LATENCY-1:0] pipe_vld_q;
   logic [ADDR_W-1:0]   pipe_addr_q [READ_LATENCY];

   logic                w_launch;
   logic                w_req;
   logic                w_acc;
   logic                w_last;
   logic                w_rd_acc;
   logic                w_pipe_busy;
   logic                w_miscompare;
   logic [DATA_W-1:0]   w_exp_wr;
   logic [DATA_W-1:0]   w_exp_rd;

   assign w_launch    = (state_q == S_IDLE) && start && (mode != 2'b00);
   assign w_req       = (state_q == S_WRITE) || (state_q == S_READ);
   assign w_acc       = w_req && !avm_waitrequest;
   assign w_last      = (remain_q == (ADDR_W+1)'(1));
   assign w_rd_acc    = (state_q == S_READ) && !avm_waitrequest;
   assign w_pipe_busy = |pipe_vld_q;

`ifdef MEMORY_TESTER_ADDR_PATTERN_EN
   assign w_exp_wr = pattern_q ^ DATA_W'(addr_q);
   assign w_exp_rd = pattern_q ^ DATA_W'(pipe_addr_q[READ_LATENCY-1]);
`else
   assign w_exp_wr = pattern_q;
   assign w_exp_rd = pattern_q;
`endif

   assign w_miscompare = pipe_vld_q[READ_LATENCY-1] && (avm_readdata != w_exp_rd);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if ((mode == 2'b00) || (word_count == '0)) begin
                  state_d = S_DONE;
               end else if (mode[0]) begin
                  state_d = S_WRITE;
               end else begin
                  state_d = S_READ;
               end
            end
         end
         S_WRITE: begin
            if (w_acc && w_last) begin
               state_d = verify_q ? S_READ : S_DONE;
            end
         end
         S_READ: begin
            if (w_acc && w_last) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (!w_pipe_busy) begin
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy           = 1'b0;
      done           = 1'b0;
      avm_write      = 1'b0;
      avm_read       = 1'b0;
      case (state_q)
         S_WRITE: begin
            busy      = 1'b1;
            avm_write = 1'b1;
         end
         S_READ: begin
            busy     = 1'b1;
            avm_read = 1'b1;
         end
         S_DRAIN: busy = 1'b1;
         S_DONE:  done = 1'b1;
         default: busy = 1'b0;
      endcase
      avm_chipselect = avm_write | avm_read;
   end

   // The address and remaining count only move on an accepted beat, which
   // keeps the request stable while the slave stalls.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         verify_q    <= 1'b0;
         base_q      <= '0;
         addr_q      <= '0;
         count_q     <= '0;
         remain_q    <= '0;
         pattern_q   <= '0;
         err_cnt_q   <= '0;
         first_err_q <= '0;
         err_seen_q  <= 1'b0;
         pipe_vld_q  <= '0;
         for (int i = 0; i < READ_LATENCY; i++) begin
            pipe_addr_q[i] <= '0;
         end
      end else begin
         if (w_launch) begin
            verify_q    <= mode[1];
            base_q      <= base_address;
            addr_q      <= base_address;
            count_q     <= word_count;
            remain_q    <= word_count;
            pattern_q   <= pattern;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            err_seen_q  <= 1'b0;
         end else begin
            if (w_acc) begin
               if (w_last) begin
                  addr_q   <= base_q;
                  remain_q <= count_q;
               end else begin
                  addr_q   <= addr_q + ADDR_W'(1);
                  remain_q <= remain_q - (ADDR_W+1)'(1);
               end
            end
            if (w_miscompare) begin
               if (err_cnt_q != 16'hFFFF) begin
                  err_cnt_q <= err_cnt_q + 16'd1;
               end
               if (!err_seen_q) begin
                  first_err_q <= pipe_addr_q[READ_LATENCY-1];
                  err_seen_q  <= 1'b1;
               end
            end
         end
         pipe_vld_q[0]  <= w_rd_acc;
         pipe_addr_q[0] <= addr_q;
         for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_vld_q[i]  <= pipe_vld_q[i-1];
            pipe_addr_q[i] <= pipe_addr_q[i-1];
         end
      end
   end

   assign error_count         = err_cnt_q;
   assign first_error_address = first_err_q;
   assign avm_address         = addr_q;
   assign avm_writedata       = w_exp_wr;
   assign avm_byteenable      = '1;
   assign avm_clken           = 1'b1;

endmodule

`default_nettype wire

// File: doc/fluid_board_soc_memory_tester.md
FLUID_BOARD_SOC_MEMORY_TESTER -- requirements
Module: fluid_board_soc_memory_tester

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, memory word-address width.
REQ-002 SHALL have parameter DATA_W, default 64, memory data width (multiple of 8).
REQ-003 SHALL have parameter READ_LATENCY, default 1, fixed cycles from accepted read to valid avm_readdata (1..4).
REQ-004 SHALL have ports:
- clk, input, 1, single clock.
- reset, input, 1, asynchronous active-high reset.
- start, input, 1, one-cycle command strobe.
- mode, input, 2, command: 01 fill, 10 verify, 11 fill then verify; 00 is a no-op.
- base_address, input, ADDR_W, first word address.
- word_count, input, ADDR_W+1, number of words (0..2^ADDR_W).
- pattern, input, DATA_W, data seed.
- busy, output, 1, command in progress.
- done, output, 1, one-cycle completion pulse.
- error_count, output, 16, saturating miscompare count.
- first_error_address, output, ADDR_W, address of first miscompare.
- avm_address, output, ADDR_W, Avalon-MM master word address.
- avm_byteenable, output, DATA_W/8, always all ones.
- avm_chipselect, output, 1, asserted with avm_read or avm_write.
- avm_write, output, 1, write request.
- avm_read, output, 1, read request.
- avm_writedata, output, DATA_W, write data.
- avm_clken, output, 1, slave clock enable, constant 1 out of reset.
- avm_readdata, input, DATA_W, slave read data.
- avm_waitrequest, input, 1, slave stall; tie 0 for on-chip memory.

Function
REQ-005 SHALL implement states IDLE, WRITE, READ, DRAIN, DONE.
REQ-006 IDLE: start with mode!=00 SHALL latch mode, base_address, word_count and pattern, clear error_count and first_error_address, assert busy next cycle, and enter WRITE (mode bit0 set) or READ.
REQ-007 start with mode=00, or with word_count=0, SHALL go straight to DONE with no bus access.
REQ-008 start while busy SHALL be ignored.
REQ-009 WRITE SHALL issue one write per cycle; a request is accepted on a cycle with avm_waitrequest=0; while stalled, avm_address, avm_writedata and the control signals SHALL stay stable.
REQ-010 The address SHALL advance by 1 per accepted access and wrap from 2^ADDR_W-1 to 0.
REQ-011 After word_count accepted writes, SHALL enter READ if mode bit1 is set, else DONE; the address restarts at base_address.
REQ-012 READ SHALL issue pipelined reads, one per cycle, with no wait for returned data; after word_count accepted reads it SHALL enter DRAIN.
REQ-013 Each accepted read SHALL push its address into a READ_LATENCY-deep delay line; avm_readdata SHALL be compared exactly READ_LATENCY cycles after acceptance against the expected word for that address.
REQ-014 DRAIN SHALL wait until the delay line is empty, then enter DONE.
REQ-015 On a miscompare, error_count SHALL increment and saturate at 0xFFFF; first_error_address SHALL capture only the first miscompare of the command.
REQ-016 DONE SHALL pulse done for one cycle, deassert busy in the same cycle, and return to IDLE.
REQ-017 Latency: with no waitrequest, N-word fill then verify SHALL take 2N+READ_LATENCY+2 cycles from start to done.
REQ-018 avm_write and avm_read SHALL never be asserted in the same cycle.
REQ-019 avm_chipselect SHALL equal avm_write OR avm_read.

Reset
REQ-020 reset SHALL force IDLE and drive the following to 0: busy, done, avm_write, avm_read, avm_chipselect, avm_address, avm_writedata, error_count, first_error_address, and the delay line.
REQ-021 avm_clken SHALL be 1 and avm_byteenable all ones in every state, including reset.
REQ-022 Reset asserted mid-command SHALL abort the command immediately with no done pulse; in-flight read data returned after reset SHALL be discarded.

Configuration
REQ-023 Macro MEMORY_TESTER_ADDR_PATTERN_EN SHALL select the data pattern.
- Defined: written and expected data = pattern XOR zero-extended word address.
- Undefined: written and expected data = pattern for every word.

Verification
REQ-024 Fill then verify: mode=11, base=0x0000, count=16, pattern=0xA5A5_A5A5_A5A5_A5A5 on the memory model -> 16 writes, then 16 reads; done pulses with error_count=0 and the cycle count from REQ-017.
REQ-025 Wrap-around: base=0x7FFE, count=4, mode=01 -> writes to 0x7FFE, 0x7FFF, 0x0000, 0x0001.
REQ-026 Miscompare: fill 8 words, corrupt word 0x0005 with a back-door write, verify -> error_count=1, first_error_address=0x0005.
REQ-027 Waitrequest: random avm_waitrequest during fill then verify -> request signals stable while stalled; exactly count accepted accesses per phase; error_count=0.
REQ-028 Zero count and mid-operation reset: count=0 -> done 1 cycle later with no access; reset pulse during READ -> busy=0, no done pulse, the next command runs clean.
